// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - Byte-stream input and program RAM port B bundle for prog_loader.
interface prog_loader_if;
  logic [7:0]  DIN;
  logic        DIN_VALID;
  logic        DIN_READY;
  logic        BRAM_EN;
  logic [3:0]  BRAM_WE;
  logic [14:0] BRAM_ADDR;
  logic [31:0] BRAM_DI;
  logic [3:0]  BRAM_DIP;
  logic        PROC_RESET;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;

  modport master (
    output DIN, DIN_VALID,
    input  DIN_READY, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI, BRAM_DIP,
    input  PROC_RESET, BUSY, DONE, ERROR
  );

  modport slave (
    input  DIN, DIN_VALID,
    output DIN_READY, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI, BRAM_DIP,
    output PROC_RESET, BUSY, DONE, ERROR
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - Framed byte-stream program loader into 18-bit program RAM with checksum check.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module prog_loader #(
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input logic       CLK,
  input logic       RST_N,
  prog_loader_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                r_state;
  logic [7:0]            r_len_h;
  logic [15:0]           r_len;
  logic [ADDR_WIDTH-1:0] r_word_addr;
  logic [7:0]            r_csum;
  logic [1:0]            r_b0;
  logic [7:0]            r_b1;
  logic                  r_din_ready;
  logic                  r_bram_en;
  logic [3:0]            r_bram_we;
  logic [14:0]           r_bram_addr;
  logic [15:0]           r_bram_di;
  logic [1:0]            r_bram_dip;
  logic                  r_proc_reset;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic                  w_accept;
  logic [15:0]           w_len;
  logic                  w_len_bad;
  logic [7:0]            w_csum_next;
  logic [ADDR_WIDTH:0]   w_addr_inc;
  logic                  w_last;

  assign w_accept    = bus.DIN_VALID & r_din_ready;
  assign w_len       = {r_len_h, bus.DIN};
  assign w_len_bad   = (w_len == 16'd0) || ({16'h0, w_len} > (32'd1 << ADDR_WIDTH));
  assign w_csum_next = r_csum + bus.DIN;
  assign w_addr_inc  = {1'b0, r_word_addr} + 1'b1;
  assign w_last      = (16'(w_addr_inc) == r_len);

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] r_tmo;
  logic        w_counting;
  assign w_counting = (r_state == S_LEN_H) || (r_state == S_LEN_L) || (r_state == S_B0) ||
                      (r_state == S_B1) || (r_state == S_B2) || (r_state == S_CSUM);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_len_h      <= '0;
      r_len        <= '0;
      r_word_addr  <= '0;
      r_csum       <= '0;
      r_b0         <= '0;
      r_b1         <= '0;
      r_din_ready  <= 1'b0;
      r_bram_en    <= 1'b0;
      r_bram_we    <= '0;
      r_bram_addr  <= '0;
      r_bram_di    <= '0;
      r_bram_dip   <= '0;
      r_proc_reset <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      r_tmo        <= '0;
`endif
    end else begin
      // Ready is only withheld for the single WRITE cycle set up from B2.
      r_din_ready <= 1'b1;
      r_bram_en   <= 1'b0;
      r_bram_we   <= '0;
      r_done      <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      if (w_accept)        r_tmo <= '0;
      else if (w_counting) r_tmo <= r_tmo + 32'd1;
`endif
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_accept && bus.DIN == SYNC_BYTE) begin
            r_proc_reset <= 1'b1;
            r_error      <= 1'b0;
            r_word_addr  <= '0;
            r_csum       <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_LEN_H;
          end
        end
        S_LEN_H: if (w_accept) begin
          r_len_h <= bus.DIN;
          r_csum  <= w_csum_next;
          r_state <= S_LEN_L;
        end
        S_LEN_L: if (w_accept) begin
          r_len  <= w_len;
          r_csum <= w_csum_next;
          if (w_len_bad) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_ERR;
          end else begin
            r_state <= S_B0;
          end
        end
        S_B0: if (w_accept) begin
          r_b0    <= bus.DIN[1:0];
          r_csum  <= w_csum_next;
          r_state <= S_B1;
        end
        S_B1: if (w_accept) begin
          r_b1    <= bus.DIN;
          r_csum  <= w_csum_next;
          r_state <= S_B2;
        end
        S_B2: if (w_accept) begin
          r_csum      <= w_csum_next;
          r_bram_en   <= 1'b1;
          r_bram_we   <= 4'hF;
          r_bram_addr <= 15'({r_word_addr, 4'b0000});
          r_bram_di   <= {r_b1, bus.DIN};
          r_bram_dip  <= r_b0;
          r_din_ready <= 1'b0;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          if (w_last) begin
            r_state <= S_CSUM;
          end else begin
            r_word_addr <= w_addr_inc[ADDR_WIDTH-1:0];
            r_state     <= S_B0;
          end
        end
        S_CSUM: if (w_accept) begin
          r_csum <= w_csum_next;
          r_busy <= 1'b0;
          if (w_csum_next == 8'd0) begin
            r_done       <= 1'b1;
            r_proc_reset <= 1'b0;
            r_state      <= S_DONE;
          end else begin
            r_error <= 1'b1;
            r_state <= S_ERR;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef LOADER_TIMEOUT_EN
      if (w_counting && !w_accept && r_tmo == 32'(TIMEOUT_CYCLES - 1)) begin
        r_error <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= S_ERR;
      end
`endif
    end
  end

  assign bus.DIN_READY  = r_din_ready;
  assign bus.BRAM_EN    = r_bram_en;
  assign bus.BRAM_WE    = r_bram_we;
  assign bus.BRAM_ADDR  = r_bram_addr;
  assign bus.BRAM_DI    = {16'h0000, r_bram_di};
  assign bus.BRAM_DIP   = {2'b00, r_bram_dip};
  assign bus.PROC_RESET = r_proc_reset;
  assign bus.BUSY       = r_busy;
  assign bus.DONE       = r_done;
  assign bus.ERROR      = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - Self-checking bench for prog_loader: vector table, random frames, corner sequences.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if bus();

  prog_loader #(.ADDR_WIDTH(10), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [14:0] a;
    logic [31:0] d;
    logic [3:0]  p;
  } wr_t;

  typedef struct {
    string        nm;
    logic [127:0] b;
    int           n;
    int           nw;
    wr_t          w0;
    wr_t          w1;
    int           nd;
    logic         err;
    logic         prst;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   ndone = 0;
  int   rst_cyc = 0;
  wr_t  wq[$];
  wr_t  eq[$];
  vec_t tv[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Observer: records writes, counts DONE pulses, and checks ready is low exactly in write cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      rst_cyc = 0;
    end else begin
      if (rst_cyc >= 1) chk("ready_vs_write", bus.DIN_READY, !bus.BRAM_EN);
      rst_cyc++;
      if (bus.BRAM_EN) begin
        chk("write_we", bus.BRAM_WE, 4'hF);
        wq.push_back({bus.BRAM_ADDR, bus.BRAM_DI, bus.BRAM_DIP});
      end
      if (bus.DONE) ndone++;
    end
  end

  task automatic send(input logic [7:0] bq[$], input int gap_pct);
    int i = 0;
    int guard = 0;
    while (i < bq.size() && guard < 20 * bq.size() + 100) begin
      @(negedge clk);
      guard++;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.DIN_VALID = 1'b0;
      end else begin
        bus.DIN       = bq[i];
        bus.DIN_VALID = 1'b1;
        if (bus.DIN_READY) i++;
      end
    end
    if (i < bq.size()) chk("send_stalled", i, bq.size());
    @(negedge clk);
    bus.DIN_VALID = 1'b0;
  endtask

  task automatic build(input logic [17:0] ws[$], input bit good, input int garbage,
                       output logic [7:0] bq[$]);
    logic [7:0]  s;
    logic [7:0]  g;
    logic [15:0] len;
    bq = {};
    for (int k = 0; k < garbage; k++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h00;
      bq.push_back(g);
    end
    len = 16'(ws.size());
    bq.push_back(8'hA5);
    bq.push_back(len[15:8]);
    bq.push_back(len[7:0]);
    foreach (ws[k]) begin
      bq.push_back({6'($urandom), ws[k][17:16]});
      bq.push_back(ws[k][15:8]);
      bq.push_back(ws[k][7:0]);
    end
    s = 8'h00;
    for (int k = garbage + 1; k < bq.size(); k++) s = s + bq[k];
    bq.push_back(8'(8'h00 - s) + (good ? 8'd0 : 8'd1));
  endtask

  task automatic expect_words(input logic [17:0] ws[$]);
    eq.delete();
    foreach (ws[k]) eq.push_back({15'(k * 16), {16'h0000, ws[k][15:0]}, {2'b00, ws[k][17:16]}});
  endtask

  task automatic check_frame(input string t, input bit good);
    chk({t, "_nwrites"}, wq.size(), eq.size());
    for (int k = 0; k < wq.size() && k < eq.size(); k++) chk({t, "_write"}, wq[k], eq[k]);
    chk({t, "_done"}, ndone, good ? 1 : 0);
    chk({t, "_error"}, bus.ERROR, !good);
    chk({t, "_proc_reset"}, bus.PROC_RESET, !good);
    chk({t, "_busy"}, bus.BUSY, 1'b0);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_ready"}, bus.DIN_READY, 1'b0);
    chk({t, "_en"}, bus.BRAM_EN, 1'b0);
    chk({t, "_we"}, bus.BRAM_WE, 4'h0);
    chk({t, "_addr"}, bus.BRAM_ADDR, 15'h0);
    chk({t, "_di"}, bus.BRAM_DI, 32'h0);
    chk({t, "_dip"}, bus.BRAM_DIP, 4'h0);
    chk({t, "_proc_reset"}, bus.PROC_RESET, 1'b0);
    chk({t, "_busy"}, bus.BUSY, 1'b0);
    chk({t, "_done"}, bus.DONE, 1'b0);
    chk({t, "_error"}, bus.ERROR, 1'b0);
  endtask

  function automatic vec_t mkv(input string nm, input logic [127:0] b, input int n, input int nw,
                               input wr_t w0, input wr_t w1, input int nd, input logic err,
                               input logic prst);
    vec_t v;
    v.nm = nm; v.b = b; v.n = n; v.nw = nw; v.w0 = w0; v.w1 = w1;
    v.nd = nd; v.err = err; v.prst = prst;
    return v;
  endfunction

  initial begin
    logic [7:0]  bq[$];
    logic [17:0] ws[$];
    wr_t         wa;
    wr_t         wb;
    bit          good;

    bus.DIN = 8'h00;
    bus.DIN_VALID = 1'b0;
    wa = {15'h0000, 32'h0000_1234, 4'h3};
    wb = {15'h0010, 32'h0000_ABCD, 4'h0};
    tv[0] = mkv("good",     {80'hA5000203123400ABCD3D, 48'h0}, 10, 2, wa, wb, 1, 1'b0, 1'b0);
    tv[1] = mkv("garbage",  {24'h00FF5A, 104'h0},               3, 0, wa, wb, 0, 1'b0, 1'b0);
    tv[2] = mkv("badcsum",  {80'hA5000203123400ABCD3E, 48'h0}, 10, 2, wa, wb, 0, 1'b1, 1'b1);
    tv[3] = mkv("recover",  {80'hA5000203123400ABCD3D, 48'h0}, 10, 2, wa, wb, 1, 1'b0, 1'b0);
    tv[4] = mkv("len0",     {24'hA50000, 104'h0},               3, 0, wa, wb, 0, 1'b1, 1'b1);
    tv[5] = mkv("len1025",  {24'hA50401, 104'h0},               3, 0, wa, wb, 0, 1'b1, 1'b1);
    tv[6] = mkv("good2",    {80'hA5000203123400ABCD3D, 48'h0}, 10, 2, wa, wb, 1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      wq.delete();
      ndone = 0;
      bq = {};
      for (int k = 0; k < tv[v].n; k++) bq.push_back(tv[v].b[127 - 8 * k -: 8]);
      send(bq, 0);
      repeat (3) @(negedge clk);
      chk({tv[v].nm, "_nwrites"}, wq.size(), tv[v].nw);
      if (tv[v].nw > 0 && wq.size() > 0) chk({tv[v].nm, "_w0"}, wq[0], tv[v].w0);
      if (tv[v].nw > 1 && wq.size() > 1) chk({tv[v].nm, "_w1"}, wq[1], tv[v].w1);
      chk({tv[v].nm, "_done"}, ndone, tv[v].nd);
      chk({tv[v].nm, "_error"}, bus.ERROR, tv[v].err);
      chk({tv[v].nm, "_proc_reset"}, bus.PROC_RESET, tv[v].prst);
      chk({tv[v].nm, "_busy"}, bus.BUSY, 1'b0);
    end

    for (int r = 0; r < 12; r++) begin
      ws = {};
      for (int k = 0; k < $urandom_range(1, 6); k++) ws.push_back(18'($urandom));
      good = ($urandom_range(0, 3) != 0);
      build(ws, good, $urandom_range(0, 3), bq);
      expect_words(ws);
      wq.delete();
      ndone = 0;
      send(bq, 30);
      repeat (3) @(negedge clk);
      check_frame("rand", good);
    end

    ws = {};
    for (int k = 0; k < 1024; k++) ws.push_back(18'($urandom));
    build(ws, 1'b1, 0, bq);
    expect_words(ws);
    wq.delete();
    ndone = 0;
    send(bq, 0);
    repeat (3) @(negedge clk);
    check_frame("full1024", 1'b1);
    if (wq.size() == 1024) chk("full1024_last_addr", wq[1023].a, 15'h3FF0);

    wq.delete();
    bq = '{8'hA5, 8'h00, 8'h02, 8'h03, 8'h12, 8'h34};
    send(bq, 0);
    @(negedge clk);
    chk("midload_one_write", wq.size(), 1);
    chk("midload_busy", bus.BUSY, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset("midload_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
    ndone = 0;
    for (int k = 0; k < 10; k++) bq[k] = tv[0].b[127 - 8 * k -: 8];
    bq = {};
    for (int k = 0; k < 10; k++) bq.push_back(tv[0].b[127 - 8 * k -: 8]);
    send(bq, 0);
    repeat (3) @(negedge clk);
    chk("after_reset_nwrites", wq.size(), 2);
    if (wq.size() > 0) chk("after_reset_w0", wq[0], wa);
    chk("after_reset_done", ndone, 1);

    bq = '{8'hA5, 8'h00};
    send(bq, 0);
    repeat (110) @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
    chk("stall_error", bus.ERROR, 1'b1);
    chk("stall_busy", bus.BUSY, 1'b0);
    chk("stall_proc_reset", bus.PROC_RESET, 1'b1);
`else
    chk("stall_error", bus.ERROR, 1'b0);
    chk("stall_busy", bus.BUSY, 1'b1);
    chk("stall_proc_reset", bus.PROC_RESET, 1'b1);
`endif

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
